// File: rtl/madd_seq.sv
// madd_seq: multi-cycle multiply-accumulate engine for the EX stage
// (MADD, MADDU, MSUB, MSUBU).
//
// The 32x32 product is built from two 16-bit partial products over two
// cycles. In the third cycle the result is added to, or subtracted from,
// the forwarded HI/LO pair. The pipeline is stalled meanwhile.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           MADD-class instruction valid in EX
//   op[1:0]         00 MADD, 01 MADDU, 10 MSUB, 11 MSUBU
//   opdata1/2       multiplicand (rs) / multiplier (rt)
//   hi_i, lo_i      current (forwarded) HI/LO
//   hold            EX frozen by a later-stage stall
//   flush           pipeline flush; abandons the operation
//   stallreq_o      stall request to PC/IF/ID/EX
//   whilo_o         HI/LO write enable (asserted in ACC only)
//   hi_o, lo_o      accumulated result (zero outside ACC)
//   cnt_o           state code: 0 IDLE, 1 MUL1, 2 ACC
module madd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        hold,
    input  logic        flush,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [1:0]  cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] a_q;       // multiplicand magnitude
    logic [15:0] b_hi_q;    // upper half of multiplier magnitude
    logic        neg_q;     // product must be negated
    logic [1:0]  op_q;
    logic [63:0] prod_q;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_in;
    logic [63:0] pp_lo;
    logic [63:0] pp_hi;
    logic [63:0] p_sum;
    logic [63:0] acc;

    // Magnitude of 0x80000000 wraps back to 0x80000000, which read as
    // unsigned is exactly 2^31, so no special case is needed.
    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
        b_mag     = (signed_op && opdata2[31]) ? (32'd0 - opdata2) : opdata2;
        neg_in    = signed_op & (opdata1[31] ^ opdata2[31]);
        pp_lo     = {32'd0, a_mag} * {48'd0, b_mag[15:0]};
        pp_hi     = {32'd0, a_q} * {48'd0, b_hi_q};
        p_sum     = prod_q + (pp_hi << 16);
        acc       = op_q[1] ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_hi_q <= '0;
            neg_q  <= 1'b0;
            op_q   <= '0;
            prod_q <= '0;
        end else if (flush) begin
            state  <= IDLE;
            prod_q <= '0;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a_mag;
                        b_hi_q <= b_mag[31:16];
                        neg_q  <= neg_in;
                        op_q   <= op;
                        prod_q <= pp_lo;
                        state  <= MUL1;
                    end
                end
                MUL1: begin
                    prod_q <= neg_q ? (64'd0 - p_sum) : p_sum;
                    state  <= ACC;
                end
                ACC:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = ((state == IDLE) && start) || (state == MUL1);
        whilo_o    = (state == ACC);
        hi_o       = whilo_o ? acc[63:32] : '0;
        lo_o       = whilo_o ? acc[31:0]  : '0;
        cnt_o      = state;
    end

endmodule

// File: tb/tb_madd_seq.sv
// Directed testbench for madd_seq. Inputs change 1 time unit after the
// rising edge; outputs are checked a further time unit later.
module tb_madd_seq;

    logic        clk = 1'b0;
    logic        rst, start, hold, flush;
    logic [1:0]  op;
    logic [31:0] opdata1, opdata2, hi_i, lo_i;
    logic        stallreq_o, whilo_o;
    logic [31:0] hi_o, lo_o;
    logic [1:0]  cnt_o;

    int checks = 0;
    int errors = 0;

    madd_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .opdata1(opdata1), .opdata2(opdata2), .hi_i(hi_i), .lo_i(lo_i),
        .hold(hold), .flush(flush), .stallreq_o(stallreq_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check control outputs plus result, settled after input changes.
    task automatic chk_all(input string tag, input logic st, input logic [1:0] c,
                           input logic w, input logic [31:0] h, input logic [31:0] l);
        #1;
        chk({tag, "_stall"}, 64'(stallreq_o), 64'(st));
        chk({tag, "_cnt"},   64'(cnt_o),      64'(c));
        chk({tag, "_whilo"}, 64'(whilo_o),    64'(w));
        chk({tag, "_hi"},    64'(hi_o),       64'(h));
        chk({tag, "_lo"},    64'(lo_o),       64'(l));
    endtask

    // Full operation with hold=0, from start cycle T through T+3 (IDLE).
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; op = o; opdata1 = a; opdata2 = b; hi_i = h; lo_i = l;
        chk_all({tag, "_T0"}, 1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
        tick();
        start = 1'b0; opdata1 = 32'h5A5A_5A5A; opdata2 = 32'hA5A5_A5A5; op = ~o;
        chk_all({tag, "_T1"}, 1'b1, 2'd1, 1'b0, 32'd0, 32'd0);
        tick();
        chk_all({tag, "_T2"}, 1'b0, 2'd2, 1'b1, eh, el);
        tick();
        chk_all({tag, "_T3"}, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; flush = 1'b0; op = 2'b00;
        opdata1 = '0; opdata2 = '0; hi_i = '0; lo_i = '0;
        tick(); tick();
        rst = 1'b0;
        chk_all("reset", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        tick();

        do_op("maddu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
              32'hFFFF_FFFE, 32'h0000_0001);
        // back-to-back: next start issued at T+3 of the previous op
        do_op("madd_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'd0, 32'h0000_000A,
              32'h0000_0000, 32'h0000_0004);
        do_op("msub_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
              32'hC000_0000, 32'h0000_0000);
        do_op("msubu_wrap", 2'b11, 32'd1, 32'd1, 32'd0, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("maddu_hi", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd5,
              32'd2, 32'd5);
        do_op("msub_mixed", 2'b10, 32'hFFFF_FFFF, 32'h0000_0007, 32'd0, 32'd0,
              32'd0, 32'd7);

        // flush in MUL1
        start = 1'b1; op = 2'b00; opdata1 = 32'd9; opdata2 = 32'd9; hi_i = '0; lo_i = '0;
        tick();
        start = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_all("flush_T2", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        tick();
        chk_all("flush_T3", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        // flush together with start: start dropped
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk_all("flush_start", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        tick();

        // hold in ACC: result held and tracks lo_i
        start = 1'b1; op = 2'b01; opdata1 = 32'd2; opdata2 = 32'd3;
        tick();
        start = 1'b0;
        tick();
        hold = 1'b1;
        chk_all("hold_T2", 1'b0, 2'd2, 1'b1, 32'd0, 32'd6);
        tick();
        chk_all("hold_T3", 1'b0, 2'd2, 1'b1, 32'd0, 32'd6);
        tick();
        lo_i = 32'd1;
        chk_all("hold_T4", 1'b0, 2'd2, 1'b1, 32'd0, 32'd7);
        tick();
        hold = 1'b0; lo_i = 32'd0;
        chk_all("hold_T5", 1'b0, 2'd2, 1'b1, 32'd0, 32'd6);
        tick();
        chk_all("hold_T6", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        // hold in IDLE with start, then hold in MUL1: -3 * 5 = -15
        start = 1'b1; hold = 1'b1; op = 2'b00; opdata1 = 32'hFFFF_FFFD; opdata2 = 32'd5;
        chk_all("holdidle_a", 1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
        tick();
        chk_all("holdidle_b", 1'b1, 2'd0, 1'b0, 32'd0, 32'd0);
        hold = 1'b0;
        tick();
        start = 1'b0; hold = 1'b1;
        chk_all("holdmul1_a", 1'b1, 2'd1, 1'b0, 32'd0, 32'd0);
        tick();
        chk_all("holdmul1_b", 1'b1, 2'd1, 1'b0, 32'd0, 32'd0);
        hold = 1'b0;
        tick();
        chk_all("holdmul1_acc", 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        tick();

        // reset mid-operation
        start = 1'b1; op = 2'b01; opdata1 = 32'd4; opdata2 = 32'd4;
        tick();
        start = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_mid", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        tick();
        chk_all("rst_after", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
